sha256_msg_padder: RTL and testbench

//  Accepts a message as a byte stream and emits the FIPS 180-4 §5.1.1 padded 512-bit blocks.

---
 rtl/sha256_pkg.sv | 16 +
 rtl/sha256_msg_padder.sv | 142 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder.
//  BLOCK_W      width of one padded SHA-256 block
//  BUF_W        message/padding buffer width (two blocks)
//  LEN_FIELD_W  width of the trailing big-endian bit-length field
//  PAD_BYTE     first padding byte appended after the message
//  MAX_BLOCKS   default blocks per message (1..2)
//  pad_state_e  padder FSM states
package sha256_pkg;
  localparam int         BLOCK_W     = 512;
  localparam int         BUF_W       = 2 * BLOCK_W;
  localparam int         LEN_FIELD_W = 64;
  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam int         MAX_BLOCKS  = 2;

  typedef enum logic [2:0] {IDLE, LOAD, PAD, EMIT0, EMIT1, DROP} pad_state_e;
endpackage

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: collects a byte-stream message (1..MAX_BYTES bytes)
// into a 128-byte buffer, appends 0x80 / zeros / 64-bit bit-length and emits
// one or two 512-bit blocks for the message scheduler.
// Ports:
//  clk, rst                     clock, asynchronous active-high reset
//  in_data/in_valid/in_last     message byte stream (first byte = MSB)
//  in_ready                     byte accepted when in_valid && in_ready
//  block_out/block_valid        padded block, word 0 in [511:480]
//  block_ready                  downstream accepts block this cycle
//  block_count, block_last      blocks in message (1/2), final-block flag
//  err_len                      one-cycle pulse: over-length message discarded
module sha256_msg_padder #(
  parameter int MAX_BLOCKS = sha256_pkg::MAX_BLOCKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [1:0]   block_count,
  output logic         block_last,
  output logic         err_len
);
  import sha256_pkg::*;

  localparam int MAX_BYTES   = 64 * MAX_BLOCKS - 9;
  localparam int ONE_BLK_MAX = 55;

  pad_state_e       state;
  logic [6:0]       cnt;
  logic [BUF_W-1:0] buffer;
  logic [BUF_W-1:0] padded;
  logic             two_blk;
  logic [9:0]       wr_lo;

  // Byte n lives at buffer[1023-8n -: 8], i.e. low bit at 1016-8n.
  assign two_blk = cnt > 7'(ONE_BLK_MAX);
  assign wr_lo   = 10'(BUF_W - 8) - {cnt, 3'b000};

  // Rewrites every byte from position len upward, so stale bytes left by an
  // earlier (longer or dropped) message never leak into the padding.
  function automatic logic [BUF_W-1:0] pad_msg(input logic [BUF_W-1:0] b,
                                              input logic [6:0] len,
                                              input logic two);
    logic [BUF_W-1:0]       r;
    logic [LEN_FIELD_W-1:0] lbits;
    int                     tail;
    r     = b;
    lbits = {54'd0, len, 3'b000};
    tail  = two ? 120 : 56;
    for (int i = 0; i < BUF_W / 8; i++) begin
      if (i == int'(len))
        r[BUF_W-1-8*i -: 8] = PAD_BYTE;
      else if (i > int'(len)) begin
        if (i >= tail && i < tail + 8)
          r[BUF_W-1-8*i -: 8] = 8'(lbits >> (8 * (tail + 7 - i)));
        else
          r[BUF_W-1-8*i -: 8] = 8'h00;
      end
    end
    return r;
  endfunction

  always_comb padded = pad_msg(buffer, cnt, two_blk);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      buffer      <= '0;
      in_ready    <= 1'b0;
      block_out   <= '0;
      block_valid <= 1'b0;
      block_count <= '0;
      block_last  <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            buffer[wr_lo +: 8] <= in_data;
            cnt                <= cnt + 7'd1;
            if (cnt == 7'(MAX_BYTES)) begin
              // Over-length byte: if it already ends the message, fail now.
              if (in_last) begin
                err_len <= 1'b1;
                cnt     <= '0;
                state   <= IDLE;
              end else begin
                state <= DROP;
              end
            end else if (in_last) begin
              in_ready <= 1'b0;
              state    <= PAD;
            end else begin
              state <= LOAD;
            end
          end
        end
        PAD: begin
          buffer      <= padded;
          block_out   <= padded[BUF_W-1 -: BLOCK_W];
          block_valid <= 1'b1;
          block_count <= two_blk ? 2'd2 : 2'd1;
          block_last  <= !two_blk;
          state       <= EMIT0;
        end
        EMIT0, EMIT1: begin
          if (block_ready) begin
            if (state == EMIT0 && block_count == 2'd2) begin
              block_out  <= buffer[BLOCK_W-1:0];
              block_last <= 1'b1;
              state      <= EMIT1;
            end else begin
              block_valid <= 1'b0;
              block_count <= '0;
              block_last  <= 1'b0;
              cnt         <= '0;
              in_ready    <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        DROP: begin
          // Counter stays at MAX_BYTES+1; bytes are swallowed until in_last.
          if (in_valid && in_ready && in_last) begin
            err_len <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;
  logic         clk;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic [1:0]   block_count;
  logic         block_last;
  logic         err_len;

  sha256_msg_padder dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .block_out(block_out), .block_valid(block_valid),
    .block_ready(block_ready), .block_count(block_count), .block_last(block_last),
    .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [511:0] blk;
    logic [1:0]   cnt;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_errs = 0;
  int   err_seen = 0;
  bit   stall_mode = 0;
  int   stall_cnt = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference padding built byte by byte from the message.
  task automatic push_model(input bq_t m);
    logic [7:0]   b [128];
    logic [63:0]  bits;
    logic [511:0] v;
    int           len;
    int           n;
    exp_t         e;
    len  = m.size();
    n    = (len <= 55) ? 1 : 2;
    bits = 64'(len) * 64'd8;
    for (int i = 0; i < 128; i++) b[i] = 8'h00;
    for (int i = 0; i < len; i++) b[i] = m[i];
    b[len] = 8'h80;
    for (int k = 0; k < 8; k++) b[64*n-8+k] = bits[63-8*k -: 8];
    for (int blk = 0; blk < n; blk++) begin
      for (int j = 0; j < 64; j++) v[511-8*j -: 8] = b[64*blk+j];
      e.blk  = v;
      e.cnt  = 2'(n);
      e.last = (blk == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic push_const(input logic [511:0] v);
    exp_t e;
    e.blk = v; e.cnt = 2'd1; e.last = 1'b1;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard;
    guard    = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Drives a whole message; expected blocks must already be queued.
  task automatic send_msg(input bq_t m);
    bit over;
    over = m.size() > 119;
    for (int i = 0; i < m.size(); i++) send_byte(m[i], i == m.size() - 1);
    if (over) begin
      exp_errs++;
      chk("err_len_pulse", err_len, 1);
      @(posedge clk); #1;
      chk("err_len_clear", err_len, 0);
      chk("err_no_block", block_valid, 0);
      chk("err_idle_ready", in_ready, 1);
      chk("err_count", err_seen, exp_errs);
    end else begin
      chk("pad_in_ready", in_ready, 0);
      chk("pad_no_valid", block_valid, 0);
      @(posedge clk); #1;
      chk("latency", block_valid, 1);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || block_valid) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic fill(output bq_t m, input int len, input logic [7:0] v, input bit incr);
    m = {};
    for (int i = 0; i < len; i++) m.push_back(incr ? 8'(i) : v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", block_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_out", block_out, 0);
    chk("rst_count", block_count, 0);
    chk("rst_last", block_last, 0);
    chk("rst_err", err_len, 0);
    sb.delete();
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);
  endtask

  // Downstream: always ready, or hold ready low for 5 cycles on each block.
  initial begin
    block_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!block_valid) begin
        block_ready = !stall_mode;
        stall_cnt   = 0;
      end else if (stall_mode && stall_cnt < 5) begin
        block_ready = 1'b0;
        stall_cnt++;
      end else begin
        block_ready = 1'b1;
        stall_cnt   = 0;
      end
    end
  end

  // Output monitor / scoreboard.
  logic [511:0] h_out;
  logic [1:0]   h_cnt;
  logic         h_last;
  bit           have_hold = 0;
  bit           idle_chk = 0;
  always @(negedge clk) begin
    if (rst) begin
      have_hold = 0;
      idle_chk  = 0;
    end else begin
      if (idle_chk) begin
        chk("b2b_valid", block_valid, 0);
        chk("b2b_ready", in_ready, 1);
        idle_chk = 0;
      end
      if (err_len) err_seen++;
      if (block_valid) begin
        chk("emit_in_ready", in_ready, 0);
        if (have_hold) begin
          chk("hold_out", block_out, h_out);
          chk("hold_count", block_count, h_cnt);
          chk("hold_last", block_last, h_last);
        end
        if (block_ready) begin
          have_hold = 0;
          if (sb.size() == 0) chk("unexpected_block", block_valid, 0);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("block_out", block_out, e.blk);
            chk("block_count", block_count, e.cnt);
            chk("block_last", block_last, e.last);
            if (e.last) idle_chk = 1;
          end
        end else begin
          have_hold = 1;
          h_out  = block_out;
          h_cnt  = block_count;
          h_last = block_last;
        end
      end else begin
        have_hold = 0;
      end
    end
  end

  initial begin
    bq_t m;
    int  guard;
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    #3;
    do_reset();

    m = {8'h61, 8'h62, 8'h63};
    push_const({32'h61626380, 448'd0, 32'h00000018});
    send_msg(m); drain();

    m = {8'h00};
    push_const({32'h00800000, 448'd0, 32'h00000008});
    send_msg(m); drain();

    fill(m, 55, 8'h41, 0); push_model(m); send_msg(m); drain();
    fill(m, 56, 8'h41, 0); push_model(m); send_msg(m); drain();
    fill(m, 119, 8'h00, 1); push_model(m); send_msg(m); drain();

    fill(m, 120, 8'h5a, 0); send_msg(m);
    fill(m, 130, 8'h00, 1); send_msg(m);
    m = {8'h61, 8'h62, 8'h63};
    push_const({32'h61626380, 448'd0, 32'h00000018});
    send_msg(m); drain();

    stall_mode = 1;
    fill(m, 56, 8'h41, 0); push_model(m); send_msg(m); drain();
    fill(m, 20, 8'h00, 1); push_model(m); send_msg(m); drain();
    stall_mode = 0;

    // Reset in the middle of loading (30 bytes in).
    for (int i = 0; i < 30; i++) send_byte(8'(i), 1'b0);
    do_reset();
    m = {8'h61, 8'h62, 8'h63};
    push_const({32'h61626380, 448'd0, 32'h00000018});
    send_msg(m); drain();

    // Reset while the second block is stalled.
    stall_mode = 1;
    fill(m, 60, 8'h33, 0); push_model(m); send_msg(m);
    guard = 0;
    while (!(block_valid && block_last) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("emit1_reached", block_last, 1);
    do_reset();
    stall_mode = 0;
    m = {8'h61, 8'h62, 8'h63};
    push_const({32'h61626380, 448'd0, 32'h00000018});
    send_msg(m); drain();

    for (int t = 0; t < 6; t++) begin
      int len;
      len = $urandom_range(1, 119);
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      stall_mode = t[0];
      push_model(m); send_msg(m); drain();
    end
    chk("final_err_count", err_seen, exp_errs);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
